// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: the control state
// encoding, the default operand width and the accumulator width.
package mult_pkg;

  localparam int MULT_WIDTH = 4;
  localparam int ACC_W      = 2 * MULT_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/mult_control.sv
// Control unit for the shift-and-add multiplier. Sequences the accumulator
// load/add/shift strobes from a level start request and the accumulator LSB,
// counts WIDTH shift steps and holds done until start is released.
module mult_control
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic st,
  input  logic m,
  output logic load,
  output logic ad,
  output logic sh,
  output logic busy,
  output logic done
);

  // The counter compares against the last step index before incrementing,
  // so it stops at WIDTH and never needs to wrap.
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // State and step-counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state and counter update; m is only looked at in CHECK, st only in
  // IDLE and DONE, so toggling st mid-operation has no effect.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (st) state_next = LOAD;
      end
      LOAD: begin
        cnt_next   = '0;
        state_next = CHECK;
      end
      CHECK: begin
        state_next = m ? ADD : SHIFT;
      end
      ADD: begin
        state_next = SHIFT;
      end
      SHIFT: begin
        cnt_next   = cnt_reg + CNT_W'(1);
        state_next = (cnt_reg == LAST_STEP) ? DONE : CHECK;
      end
      DONE: begin
        if (!st) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Moore output decode; each state asserts at most one accumulator strobe,
  // which keeps ad and sh from ever coinciding.
  always_comb begin
    load = 1'b0;
    ad   = 1'b0;
    sh   = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      LOAD: begin
        load = 1'b1;
        busy = 1'b1;
      end
      CHECK: begin
        busy = 1'b1;
      end
      ADD: begin
        ad   = 1'b1;
        busy = 1'b1;
      end
      SHIFT: begin
        sh   = 1'b1;
        busy = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        load = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_control.sv
// Self-checking bench for mult_control. A behavioural accumulator/adder built
// around the DUT supplies m, and each operation is compared cycle by cycle
// against the strobe sequence expected from the multiplier bits, plus the
// final product computed with plain multiplication.
module tb_mult_control;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic st;
  logic m;
  logic load, ad, sh, busy, done;

  logic [2*W:0]   acc;
  logic [W-1:0]   mcand;
  logic [W-1:0]   mplier;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mult_control #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .st   (st),
    .m    (m),
    .load (load),
    .ad   (ad),
    .sh   (sh),
    .busy (busy),
    .done (done)
  );

  // Behavioural accumulator and adder driven by the DUT strobes.
  always @(posedge clk) begin
    if (!rst_n)    acc <= '0;
    else if (load) acc <= {{(W+1){1'b0}}, mplier};
    else if (ad)   acc[2*W:W] <= {1'b0, acc[2*W-1:W]} + {1'b0, mcand};
    else if (sh)   acc <= acc >> 1;
  end

  assign m = acc[0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return {27'd0, load, ad, sh, busy, done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full multiply: single-cycle st pulse, random st during busy, then
  // st held for 'hold' DONE cycles before release.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    logic [4:0] exp_q[$];
    int ones;
    int edges;
    ones   = 0;
    mcand  = a;
    mplier = b;
    // Expected {load,ad,sh,busy,done} per busy cycle, straight from the bits.
    exp_q.push_back(5'b10010);
    for (int i = 0; i < W; i++) begin
      exp_q.push_back(5'b00010);
      if (b[i]) begin
        exp_q.push_back(5'b01010);
        ones++;
      end
      exp_q.push_back(5'b00110);
    end
    chk("idle_before_start", outs(), 32'd0);
    st = 1'b1;
    tick();
    edges = 1;
    st = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      chk($sformatf("trace_%0h_%0h_c%0d", a, b, k), outs(), {27'd0, exp_q[k]});
      st = 1'($urandom_range(0, 1));
      tick();
      edges++;
    end
    while (!done && edges < 40) begin
      tick();
      edges++;
    end
    chk("latency", edges, 2 + 2 * W + ones);
    chk("done_entry", outs(), 32'd1);
    chk("product", {24'd0, acc[2*W-1:0]}, 32'(a) * 32'(b));
    st = 1'b1;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("done_hold", outs(), 32'd1);
    end
    st = 1'b0;
    tick();
    chk("release_idle", outs(), 32'd0);
    $display("op mcand=%0d mplier=%0d product=%0d latency=%0d hold=%0d",
             a, b, acc[2*W-1:0], edges, hold);
  endtask

  initial begin
    int waited;
    rst_n  = 1'b0;
    st     = 1'b1;
    mcand  = '0;
    mplier = '0;
    tick();
    chk("reset_c1", outs(), 32'd0);
    tick();
    chk("reset_c2", outs(), 32'd0);
    rst_n = 1'b1;
    st    = 1'b0;
    tick();
    chk("after_reset_idle", outs(), 32'd0);
    tick();
    chk("idle_stays", outs(), 32'd0);
    $display("reset sequence done");

    run_op(4'($urandom), 4'b0000, 0);
    run_op(4'($urandom), 4'b1010, 1);
    run_op(4'b1101, 4'b1011, 6);
    run_op(4'b1111, 4'b1111, 2);

    // Reset while the accumulator add strobe is up.
    mcand  = 4'($urandom);
    mplier = 4'($urandom) | 4'b0001;
    st = 1'b1;
    tick();
    st = 1'b0;
    waited = 0;
    while (!ad && waited < 10) begin
      tick();
      waited++;
    end
    chk("reach_add", {31'd0, ad}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_reset_outs", outs(), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("mid_reset_idle", outs(), 32'd0);
    $display("mid-operation reset mcand=%0d mplier=%0d", mcand, mplier);

    for (int r = 0; r < 8; r++) begin
      run_op(4'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
